pwm_fader: RTL and testbench
============================

// Module: pwm_fader
//
// PURPOSE
//   Multi-channel PWM LED brightness driver, successor to the single-channel 4-bit dimmer.
//   Each channel has its own WIDTH-bit brightness target. It either jumps to that target
//   or fades toward it one step at a time. Duty changes take effect only at PWM period
//   boundaries, so outputs never glitch. Sits between switch/register inputs and the LED pins.
//
// PARAMETERS
//   CHANNELS      4   number of independent PWM outputs (>=1)
//   WIDTH         8   brightness/counter width; PWM period = 2**WIDTH ticks
//   PRESCALE      1   CLK cycles per PWM tick (>=1)
//   RAMP_PERIODS  1   PWM periods per fade step (>=1)
//
// PORTS
//   CLK           in   1               system clock, all logic on rising edge
//   RST_N         in   1               asynchronous, active-low reset
//   EN            in   1               run enable
//   TARGET        in   CHANNELS*WIDTH  per-channel target; ch i = [i*WIDTH +: WIDTH]
//   FADE          in   CHANNELS        per-channel mode: 1 = ramp by 1 step, 0 = jump
//   PWM_OUT       out  CHANNELS        registered PWM outputs
//   LEVEL         out  CHANNELS*WIDTH  current applied brightness per channel
//   SETTLED       out  CHANNELS        1 when LEVEL[i] == TARGET[i] (combinational)
//   PERIOD_START  out  1               one-CLK pulse marking start of each PWM period
//
// BEHAVIOUR
//   - Reset (RST_N low, async): pre_cnt, ctr, ramp_cnt, all LEVEL, PWM_OUT and
//     PERIOD_START go to 0 at once. Reset mid-fade drops the fade; no state is kept.
//   - Prescaler: pre_cnt counts 0..PRESCALE-1. tick = EN && pre_cnt==PRESCALE-1.
//   - Period counter: ctr (WIDTH bits) increments on tick. It wraps 2**WIDTH-1 -> 0
//     by natural overflow. boundary = tick && ctr==2**WIDTH-1.
//   - PERIOD_START is registered. It is 1 for exactly the one cycle after a boundary,
//     when ctr has just become 0.
//   - Level update happens only on boundary, per channel i. TARGET and FADE are sampled
//     only then; changes within a period have no effect until the next boundary.
//       FADE[i]=0: LEVEL[i] <= TARGET[i].
//       FADE[i]=1, ramp_cnt==RAMP_PERIODS-1: LEVEL[i] steps +1 toward TARGET[i] if
//         below it, or -1 if above it. It never overshoots and has no wrap-around
//         (0 stays 0, max stays max).
//       ramp_cnt counts boundaries 0..RAMP_PERIODS-1 and wraps to 0. It is shared by
//         all channels.
//   - PWM output: each cycle, PWM_OUT[i] <= EN && (ctr < LEVEL[i]) (unsigned compare).
//     This gives 1 CLK of latency from ctr/LEVEL.
//       LEVEL=0: always low.
//       LEVEL=L: high for L*PRESCALE of every 2**WIDTH*PRESCALE cycles.
//       LEVEL=max: high for 2**WIDTH-1 of 2**WIDTH ticks (never 100%, by design).
//   - EN low:
//       pre_cnt, ctr and ramp_cnt are synchronously cleared to 0.
//       LEVEL is frozen.
//       PWM_OUT goes to 0 on the next edge.
//       PERIOD_START stays 0.
//     When EN returns high, a fresh period starts at ctr=0.
//   - First period after reset: LEVEL=0 (outputs dark). TARGET is first applied at the
//     first boundary.
//   - A TARGET change on the same cycle as a boundary is taken (the sample is the
//     value present on that edge).
//   - SETTLED[i] is combinational from the LEVEL register and the TARGET input. It
//     can toggle mid-period when TARGET moves.
//
// TESTING  (WIDTH=4, PRESCALE=1, CHANNELS=2 unless stated)
//   1. FADE=00, TARGET ch0=5 -> after first PERIOD_START, PWM_OUT[0] high exactly 5 of
//      every 16 cycles; LEVEL ch0=5, SETTLED[0]=1.
//   2. Extremes: TARGET=0 -> PWM_OUT never high; TARGET=15 -> high 15/16, low 1 cycle
//      per period; PRESCALE=3 -> high 15/16 of 48-cycle period.
//   3. RAMP_PERIODS=2, FADE[1]=1, LEVEL ch1=0, TARGET ch1=3 -> LEVEL becomes 1,2,3 at
//      boundaries 2,4,6; SETTLED[1] rises with the 3; TARGET=1 then ramps 3->2->1.
//   4. Change TARGET ch0 5->9 mid-period -> duty stays 5 until next PERIOD_START, then 9.
//   5. Drop EN for 7 cycles mid-period -> PWM_OUT=0 from next edge, LEVEL held; on EN
//      high, 16 ticks later PERIOD_START pulses.
//   6. Assert RST_N low mid-fade (between clock edges) -> all outputs 0 immediately;
//      after release, fade restarts from LEVEL=0.

Source files
------------

// File: rtl/pwm_fader.sv
// pwm_fader: multi-channel PWM LED brightness driver.
//   Each channel holds an applied brightness LEVEL that either jumps to its
//   TARGET or fades toward it one step per RAMP_PERIODS PWM periods. LEVEL only
//   changes at PWM period boundaries so PWM_OUT never glitches mid-period.
//
// Ports:
//   CLK           system clock, rising edge
//   RST_N         asynchronous active-low reset
//   EN            run enable; low clears the timebase and forces outputs low
//   TARGET        per-channel target, channel i = [i*WIDTH +: WIDTH]
//   FADE          per-channel mode: 1 = ramp by one step, 0 = jump
//   PWM_OUT       registered PWM outputs
//   LEVEL         currently applied brightness per channel
//   SETTLED       combinational LEVEL == TARGET per channel
//   PERIOD_START  one-cycle pulse while the period counter sits at 0 after a wrap
module pwm_fader #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PRESCALE     = 1,
  parameter int unsigned RAMP_PERIODS = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic [CHANNELS*WIDTH-1:0] TARGET,
  input  logic [CHANNELS-1:0]       FADE,
  output logic [CHANNELS-1:0]       PWM_OUT,
  output logic [CHANNELS*WIDTH-1:0] LEVEL,
  output logic [CHANNELS-1:0]       SETTLED,
  output logic                      PERIOD_START
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PW-1:0]    PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [RW-1:0]    RAMP_LAST = RW'(RAMP_PERIODS - 1);
  localparam logic [WIDTH-1:0] CTR_LAST  = '1;

  logic [PW-1:0]             pre_cnt;
  logic [WIDTH-1:0]          ctr;
  logic [RW-1:0]             ramp_cnt;
  logic                      tick;
  logic                      boundary;
  logic                      ramp_step;
  logic [CHANNELS*WIDTH-1:0] level_next;

  always_comb begin
    tick      = EN && (pre_cnt == PRE_LAST);
    boundary  = tick && (ctr == CTR_LAST);
    ramp_step = (ramp_cnt == RAMP_LAST);
  end

  // Next applied level, only loaded on a period boundary. The ramp compares
  // before stepping, so it can neither overshoot nor wrap at 0 or max.
  always_comb begin
    level_next = LEVEL;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!FADE[i]) begin
        level_next[i*WIDTH +: WIDTH] = TARGET[i*WIDTH +: WIDTH];
      end else if (ramp_step) begin
        if (LEVEL[i*WIDTH +: WIDTH] < TARGET[i*WIDTH +: WIDTH])
          level_next[i*WIDTH +: WIDTH] = LEVEL[i*WIDTH +: WIDTH] + WIDTH'(1);
        else if (LEVEL[i*WIDTH +: WIDTH] > TARGET[i*WIDTH +: WIDTH])
          level_next[i*WIDTH +: WIDTH] = LEVEL[i*WIDTH +: WIDTH] - WIDTH'(1);
      end
    end
  end

  always_comb begin
    SETTLED = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      SETTLED[i] = (LEVEL[i*WIDTH +: WIDTH] == TARGET[i*WIDTH +: WIDTH]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt      <= '0;
      ctr          <= '0;
      ramp_cnt     <= '0;
      LEVEL        <= '0;
      PWM_OUT      <= '0;
      PERIOD_START <= 1'b0;
    end else if (!EN) begin
      // LEVEL is deliberately left untouched so brightness resumes unchanged.
      pre_cnt      <= '0;
      ctr          <= '0;
      ramp_cnt     <= '0;
      PWM_OUT      <= '0;
      PERIOD_START <= 1'b0;
    end else begin
      pre_cnt      <= tick ? '0 : pre_cnt + PW'(1);
      if (tick)
        ctr <= ctr + WIDTH'(1);
      PERIOD_START <= boundary;
      // Compares the pre-update ctr/LEVEL: one cycle of latency by design.
      for (int unsigned i = 0; i < CHANNELS; i++)
        PWM_OUT[i] <= (ctr < LEVEL[i*WIDTH +: WIDTH]);
      if (boundary) begin
        ramp_cnt <= ramp_step ? '0 : ramp_cnt + RW'(1);
        LEVEL    <= level_next;
      end
    end
  end

endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: directed bench for pwm_fader with WIDTH=4, CHANNELS=2.
//   dut   : PRESCALE=1, RAMP_PERIODS=2 (jump, fade, enable and reset cases)
//   dut_p : PRESCALE=3, RAMP_PERIODS=1 (prescaled extreme duty)
module tb_pwm_fader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] target;
  logic [1:0] fade;
  logic [1:0] pwm;
  logic [7:0] level;
  logic [1:0] settled;
  logic       ps;

  logic [7:0] target_p;
  logic [1:0] fade_p;
  logic [1:0] pwm_p;
  logic [7:0] level_p;
  logic [1:0] settled_p;
  logic       ps_p;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_fader #(.CHANNELS(2), .WIDTH(4), .PRESCALE(1), .RAMP_PERIODS(2)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .TARGET(target), .FADE(fade),
    .PWM_OUT(pwm), .LEVEL(level), .SETTLED(settled), .PERIOD_START(ps)
  );

  pwm_fader #(.CHANNELS(2), .WIDTH(4), .PRESCALE(3), .RAMP_PERIODS(1)) dut_p (
    .CLK(clk), .RST_N(rst_n), .EN(en), .TARGET(target_p), .FADE(fade_p),
    .PWM_OUT(pwm_p), .LEVEL(level_p), .SETTLED(settled_p), .PERIOD_START(ps_p)
  );

  typedef struct {
    logic [3:0] t0;
    logic [3:0] t1;
    int         hi0;
    int         hi1;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Step negedges until PERIOD_START is seen; n = number of negedges taken.
  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps && n < 200);
    if (!ps) check("wait_ps_timeout", n, -1);
  endtask

  task automatic wait_ps_p();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps_p && n < 400);
    if (!ps_p) check("wait_ps_p_timeout", n, -1);
  endtask

  task automatic count_high(input int cycles, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    repeat (cycles) begin
      @(negedge clk);
      c0 += int'(pwm[0]);
      c1 += int'(pwm[1]);
    end
  endtask

  initial begin
    vec_t vecs[4];
    int n, c0, c1, d0, d1, bad;
    int exp_lv[10];
    int exp_st[10];

    vecs[0] = '{t0: 4'd5,  t1: 4'd0,  hi0: 5,  hi1: 0};
    vecs[1] = '{t0: 4'd0,  t1: 4'd15, hi0: 0,  hi1: 15};
    vecs[2] = '{t0: 4'd15, t1: 4'd7,  hi0: 15, hi1: 7};
    vecs[3] = '{t0: 4'd9,  t1: 4'd1,  hi0: 9,  hi1: 1};

    exp_lv = '{0, 1, 1, 2, 2, 3, 3, 2, 2, 1};
    exp_st = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};

    rst_n    = 1'b0;
    en       = 1'b0;
    target   = 8'h00;
    fade     = 2'b00;
    target_p = {4'd0, 4'd15};
    fade_p   = 2'b00;

    repeat (3) @(negedge clk);
    check("reset_level", int'(level), 0);
    check("reset_pwm", int'(pwm), 0);
    check("reset_ps", int'(ps), 0);

    rst_n  = 1'b1;
    en     = 1'b1;
    target = {4'd0, 4'd5};

    // First period after reset stays dark until the first boundary.
    bad = 0;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
      bad += int'(pwm != 2'b00);
    end while (!ps && n < 200);
    check("first_period_dark", bad, 0);
    check("first_ps_latency", n, 16);
    check("first_level_ch0", int'(level[3:0]), 5);
    check("first_settled_ch0", int'(settled[0]), 1);

    // Jump mode: duty over one full period equals the target.
    for (int i = 0; i < 4; i++) begin
      target = {vecs[i].t1, vecs[i].t0};
      wait_ps(n);
      count_high(16, c0, c1);
      check("vec_hi_ch0", c0, vecs[i].hi0);
      check("vec_hi_ch1", c1, vecs[i].hi1);
      check("vec_level", int'(level), int'({vecs[i].t1, vecs[i].t0}));
      check("vec_settled", int'(settled), 3);
      check("vec_ps_after_16", int'(ps), 1);
    end

    // Mid-period target change is deferred to the next boundary.
    target = {4'd2, 4'd5};
    wait_ps(n);
    count_high(3, c0, c1);
    target[3:0] = 4'd9;
    #1;
    check("midchg_settled_drop", int'(settled[0]), 0);
    check("midchg_level_held", int'(level[3:0]), 5);
    count_high(13, d0, d1);
    check("midchg_old_duty", c0 + d0, 5);
    check("midchg_new_level", int'(level[3:0]), 9);
    count_high(16, c0, c1);
    check("midchg_new_duty", c0, 9);

    // Enable drop for 7 cycles mid-period.
    count_high(5, c0, c1);
    en = 1'b0;
    @(negedge clk);
    check("en_low_pwm", int'(pwm), 0);
    check("en_low_ps", int'(ps), 0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      bad += int'(pwm != 2'b00) + int'(ps) + int'(level != {4'd2, 4'd9});
    end
    check("en_low_hold", bad, 0);
    en = 1'b1;
    wait_ps(n);
    check("en_resume_ps_latency", n, 16);
    check("en_resume_level", int'(level), int'({4'd2, 4'd9}));

    // Prescaled extremes: steady-state 48-cycle windows.
    wait_ps_p();
    wait_ps_p();
    c0 = 0;
    c1 = 0;
    repeat (48) begin
      @(negedge clk);
      c0 += int'(pwm_p[0]);
      c1 += int'(pwm_p[1]);
    end
    check("p3_hi_ch0_max", c0, 45);
    check("p3_hi_ch1_zero", c1, 0);
    check("p3_level", int'(level_p), int'({4'd0, 4'd15}));

    // Fade, then reset between clock edges mid-fade.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    fade   = 2'b10;
    target = {4'd3, 4'd5};
    repeat (4) wait_ps(n);
    check("fade_pre_reset_level1", int'(level[7:4]), 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_level", int'(level), 0);
    check("async_rst_pwm", int'(pwm), 0);
    check("async_rst_ps", int'(ps), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp 0 -> 3 then back to 1, one step per two boundaries.
    for (int b = 0; b < 10; b++) begin
      if (b == 6) target[7:4] = 4'd1;
      wait_ps(n);
      check("ramp_level1", int'(level[7:4]), exp_lv[b]);
      check("ramp_settled1", int'(settled[1]), exp_st[b]);
      check("ramp_level0_jump", int'(level[3:0]), 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
